// File: rtl/reg_write_queue.sv
// Write-buffering FIFO in front of the register file write port, with read forwarding.
// Optional macro REG_WRITE_QUEUE_COALESCE_EN merges a request into the youngest entry on an address match.
module reg_write_queue #(
  parameter int WORD_LEN = 8,
  parameter int ADDR_LEN = 4,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_LEN-1:0]       in_addr,
  input  logic [WORD_LEN-1:0]       in_data,
  input  logic                      drain_en,
  output logic                      wr_en,
  output logic [ADDR_LEN-1:0]       wr_addr,
  output logic [WORD_LEN-1:0]       wr_data,
  input  logic [ADDR_LEN-1:0]       fwd_addr_a,
  input  logic [ADDR_LEN-1:0]       fwd_addr_b,
  output logic                      fwd_hit_a,
  output logic [WORD_LEN-1:0]       fwd_data_a,
  output logic                      fwd_hit_b,
  output logic [WORD_LEN-1:0]       fwd_data_b,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_LEN-1:0] q_addr [DEPTH];
  logic [WORD_LEN-1:0] q_data [DEPTH];
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic                push;
  logic                pop;
  logic                merge;
  logic                alloc;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign in_ready = rst_n && !full;
  assign pop      = rst_n && drain_en && !empty;
  assign wr_en    = pop;
  assign wr_addr  = q_addr[head];
  assign wr_data  = q_data[head];
  assign push     = in_valid && in_ready;

`ifdef REG_WRITE_QUEUE_COALESCE_EN
  logic [PTR_W-1:0] young;
  assign young = tail - PTR_W'(1);
  // The youngest entry is only mergeable if it is not leaving this cycle.
  assign merge = push && !empty && (q_addr[young] == in_addr)
                 && !(pop && (count == CNT_W'(1)));
`else
  assign merge = 1'b0;
`endif

  assign alloc = push && !merge;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (alloc) tail <= tail + PTR_W'(1);
      if (pop)   head <= head + PTR_W'(1);
      case ({alloc, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Entry storage carries no reset; validity comes only from count.
  always_ff @(posedge clk) begin
    if (alloc) begin
      q_addr[tail] <= in_addr;
      q_data[tail] <= in_data;
    end
`ifdef REG_WRITE_QUEUE_COALESCE_EN
    if (merge) q_data[young] <= in_data;
`endif
  end

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    fwd_hit_a  = 1'b0;
    fwd_data_a = '0;
    fwd_hit_b  = 1'b0;
    fwd_data_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        if (q_addr[head + PTR_W'(i)] == fwd_addr_a) begin
          fwd_hit_a  = 1'b1;
          fwd_data_a = q_data[head + PTR_W'(i)];
        end
        if (q_addr[head + PTR_W'(i)] == fwd_addr_b) begin
          fwd_hit_b  = 1'b1;
          fwd_data_b = q_data[head + PTR_W'(i)];
        end
      end
    end
  end

endmodule

// File: doc/reg_write_queue.md
Name: reg_write_queue

Overview:
- Write-buffering stage directly upstream of the register file's single write port.
- Accepts write requests (addr, data) over a valid/ready handshake and queues them in a DEPTH-entry FIFO.
- Drains one entry per cycle into the register file when drain_en is high.
- Forwards not-yet-written data to the register file's two read ports so readers always see the newest value.

Parameters:
WORD_LEN, 8, data word width; matches the register file.
ADDR_LEN, 4, register address width; matches the register file.
DEPTH, 4, queue entries; power of two, >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  write request valid
in_ready  output  1  queue can accept a request
in_addr  input  ADDR_LEN  request register address
in_data  input  WORD_LEN  request data
drain_en  input  1  permits draining one entry this cycle
wr_en  output  1  to register file write_en
wr_addr  output  ADDR_LEN  to register file write_addr
wr_data  output  WORD_LEN  to register file data_in
fwd_addr_a  input  ADDR_LEN  mirror of register file read_addr_a
fwd_addr_b  input  ADDR_LEN  mirror of register file read_addr_b
fwd_hit_a  output  1  pending entry matches fwd_addr_a
fwd_data_a  output  WORD_LEN  newest pending data for fwd_addr_a
fwd_hit_b  output  1  same, port b
fwd_data_b  output  WORD_LEN  same, port b
count  output  $clog2(DEPTH)+1  occupied entries
empty  output  1  count == 0
full  output  1  count == DEPTH

Behaviour:
- State: entry array, head/tail pointers (log2 DEPTH bits, natural wrap), count register. All state updates occur on the clk rising edge.
- Reset: on a clk edge with rst_n=0, set count=0 and head=tail=0. Entry contents are don't-care. While rst_n=0, force in_ready=0 and wr_en=0.
- After reset: empty=1, full=0, in_ready=1, wr_en=0, fwd_hit_a/b=0. fwd_data_a/b and wr_addr/wr_data are don't-care whenever the corresponding hit/wr_en is 0.
- in_ready = !full. It is registered-derived and has no combinational path from in_valid or drain_en.
- Push: in_valid && in_ready. Write the entry at tail; tail+1.
- Pop: drain_en && !empty.
  - wr_en is asserted combinationally with wr_addr/wr_data = head entry.
  - The register file captures the entry on the same edge that head advances (head+1).
- Latency: a request accepted at edge N is drainable from cycle N+1. With drain_en held high it is written to the register file at edge N+1 when the queue was empty.
- Push and pop in the same cycle: count unchanged. This is legal at any non-full, non-empty occupancy.
- Full: in_ready=0, and pushes are ignored even if a pop occurs that cycle.
- Empty: wr_en=0 regardless of drain_en.
- Forwarding: fwd_hit_x=1 iff any valid entry's addr == fwd_addr_x. fwd_data_x = data of the youngest matching entry (closest to tail). This logic is purely combinational.
  - The entry being popped this cycle still counts as valid for forwarding; the register file holds it from the next cycle.
  - A request accepted this cycle is not visible to forwarding until the next cycle.
- Duplicate addresses in the queue are allowed; write order is preserved (FIFO).
- Reset mid-operation: all pending entries are discarded, never written, and no wr_en pulse occurs.

Optional Feature:
- Macro: REG_WRITE_QUEUE_COALESCE_EN.
- Defined: an accepted request whose in_addr equals the youngest valid entry's addr overwrites that entry's data; tail and count are unchanged. This applies only if that entry is not being popped in the same cycle; otherwise the request allocates normally. in_ready stays !full.
- Undefined: every accepted request allocates a new entry.

Test Plan:
- Reset then idle: rst_n=0 one edge -> count=0, empty=1, in_ready=1 after release, wr_en=0, fwd_hit_a=0.
- Single write: push (addr 3, data 0xA5) with drain_en=0 -> fwd_hit_a=1, fwd_data_a=0xA5 for fwd_addr_a=3. Raise drain_en -> one wr_en pulse with wr_addr=3, wr_data=0xA5; count returns to 0.
- Fill and back-pressure: drain_en=0, push 4 requests (addr 0..3, data 0x10..0x13) -> full=1, in_ready=0. A 5th in_valid is ignored. Drain -> writes occur in order 0x10, 0x11, 0x12, 0x13.
- Youngest-wins forwarding: push (5, 0x11) then (5, 0x22), no drain -> fwd_data_b=0x22 for fwd_addr_b=5. With the macro undefined, count=2; with REG_WRITE_QUEUE_COALESCE_EN defined, count=1 and a single write of 0x22.
- Simultaneous push/pop: occupancy 2, in_valid=1 and drain_en=1 for 6 cycles -> count stays 2, one wr_en per cycle, writes in FIFO order with tail/head wrap-around.
- Reset mid-operation: 3 entries pending, rst_n=0 one edge -> count=0, no wr_en during or after reset, and fwd_hit_a=fwd_hit_b=0.
